// File: rtl/wishbone_master_if_p.sv
// Wishbone classic master: turns a single-cycle CPU request into a bus cycle,
// with retry, timeout and pipeline-flush handling.
module wishbone_master_if_p #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int STALL_W   = 6,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall_i,
  input  logic                 flush_i,
  input  logic                 cpu_ce_i,
  input  logic                 cpu_we_i,
  input  logic [AW-1:0]        cpu_addr_i,
  input  logic [DW-1:0]        cpu_data_i,
  input  logic [DW/8-1:0]      cpu_sel_i,
  output logic [DW-1:0]        cpu_data_o,
  output logic                 stallreq_o,
  output logic                 bus_err_o,
  input  logic [DW-1:0]        wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  input  logic                 wb_rty_i,
  output logic [AW-1:0]        wb_adr_o,
  output logic [DW-1:0]        wb_dat_o,
  output logic                 wb_we_o,
  output logic [DW/8-1:0]      wb_sel_o,
  output logic                 wb_stb_o,
  output logic                 wb_cyc_o
);

  localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] RETRY_LAST = CW'(MAX_RETRY);
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] RETRY = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]    state;
  logic [DW-1:0] rd_buf;
  logic [CW-1:0] retry_cnt;
  logic [TW-1:0] timer;

  logic timed_out, rty_spent;
  logic take_ack, take_err, take_rty, take_flush, busy_wait;
  logic launch, end_bus;

  // Exhausted retries and timeout both fold into the error path.
  always_comb begin
    timed_out  = (TIMEOUT != 0) && (timer == TIMER_LAST);
    rty_spent  = (retry_cnt == RETRY_LAST);
    take_ack   = (state == BUSY) && wb_ack_i;
    take_err   = (state == BUSY) && !wb_ack_i &&
                 (wb_err_i || (wb_rty_i ? rty_spent : timed_out));
    take_rty   = (state == BUSY) && !wb_ack_i && !wb_err_i && wb_rty_i && !rty_spent;
    take_flush = (state == BUSY) && !wb_ack_i && !wb_err_i && !wb_rty_i &&
                 !timed_out && flush_i;
    busy_wait  = (state == BUSY) && !(take_ack || take_err || take_rty || take_flush);
    launch     = (state == IDLE) && cpu_ce_i && !flush_i;
    end_bus    = take_ack || take_err || take_flush || ((state == RETRY) && flush_i);
  end

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    if (!rst) begin
      case (state)
        IDLE:  stallreq_o = launch;
        BUSY: begin
          stallreq_o = !(take_ack || take_err);
          if (take_ack && !wb_we_o) cpu_data_o = wb_dat_i;
        end
        RETRY: stallreq_o = 1'b1;
        HOLD:  cpu_data_o = rd_buf;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      rd_buf    <= '0;
      retry_cnt <= '0;
      timer     <= '0;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= take_err;

      // Address/data/sel stay put across a retry gap so the reissue reuses them.
      if (launch) begin
        wb_adr_o <= cpu_addr_i;
        wb_dat_o <= cpu_data_i;
        wb_we_o  <= cpu_we_i;
        wb_sel_o <= cpu_sel_i;
        wb_stb_o <= 1'b1;
        wb_cyc_o <= 1'b1;
      end else if (end_bus) begin
        wb_adr_o <= '0;
        wb_dat_o <= '0;
        wb_we_o  <= 1'b0;
        wb_sel_o <= '0;
        wb_stb_o <= 1'b0;
        wb_cyc_o <= 1'b0;
      end else if (take_rty) begin
        wb_stb_o <= 1'b0;
        wb_cyc_o <= 1'b0;
      end else if (state == RETRY) begin
        wb_stb_o <= 1'b1;
        wb_cyc_o <= 1'b1;
      end

      if (launch)        retry_cnt <= '0;
      else if (take_rty) retry_cnt <= retry_cnt + 1'b1;

      if (launch || (state == RETRY)) timer <= '0;
      else if (busy_wait)             timer <= timer + 1'b1;

      if (take_ack)                    rd_buf <= wb_we_o ? '0 : wb_dat_i;
      else if (take_err || take_flush) rd_buf <= '0;

      case (state)
        IDLE:  if (launch) state <= BUSY;
        BUSY: begin
          if (take_ack || take_err) state <= (|stall_i) ? HOLD : IDLE;
          else if (take_rty)        state <= RETRY;
          else if (take_flush)      state <= IDLE;
        end
        RETRY: state <= flush_i ? IDLE : BUSY;
        HOLD:  if (stall_i == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_master_if_p.sv
// Directed bench for wishbone_master_if_p: a transaction-level model checks
// every output each cycle, and literal checks pin the key scenarios.
module tb_wishbone_master_if_p;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int SWW  = 6;
  localparam int MAXR = 3;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SWW-1:0]  stall_i = '0;
  logic            flush_i = 1'b0;
  logic            cpu_ce_i = 1'b0;
  logic            cpu_we_i = 1'b0;
  logic [AW-1:0]   cpu_addr_i = '0;
  logic [DW-1:0]   cpu_data_i = '0;
  logic [DW/8-1:0] cpu_sel_i = '0;
  logic [DW-1:0]   cpu_data_o;
  logic            stallreq_o;
  logic            bus_err_o;
  logic [DW-1:0]   wb_dat_i = '0;
  logic            wb_ack_i = 1'b0;
  logic            wb_err_i = 1'b0;
  logic            wb_rty_i = 1'b0;
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_we_o;
  logic [DW/8-1:0] wb_sel_o;
  logic            wb_stb_o;
  logic            wb_cyc_o;

  wishbone_master_if_p #(
    .DW(DW), .AW(AW), .STALL_W(SWW), .MAX_RETRY(MAXR), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a request is either on the bus, in a retry gap, or finished and
  // possibly parked while the pipeline is stalled.
  logic           m_active, m_gap, m_hold, m_err, m_we;
  logic [AW-1:0]  m_adr;
  logic [DW-1:0]  m_dat, m_hold_data;
  logic [3:0]     m_sel;
  int             m_tries, m_waited;

  initial begin : model
    logic is_ack, is_err, e_stall;
    logic [DW-1:0] e_data;
    m_active = 0; m_gap = 0; m_hold = 0; m_err = 0; m_we = 0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_hold_data = '0;
    m_tries = 0; m_waited = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        is_ack = m_active && wb_ack_i;
        is_err = m_active && !wb_ack_i &&
                 (wb_err_i || (wb_rty_i ? (m_tries >= MAXR) : (m_waited + 1 >= TO)));
        e_stall = 1'b0;
        e_data  = '0;
        if (!rst) begin
          if (m_active) begin
            e_stall = !(is_ack || is_err);
            if (is_ack && !m_we) e_data = wb_dat_i;
          end else if (m_gap)  e_stall = 1'b1;
          else if (m_hold)     e_data = m_hold_data;
          else                 e_stall = cpu_ce_i && !flush_i;
        end
        check("stallreq_o", stallreq_o, e_stall);
        check("cpu_data_o", cpu_data_o, e_data);
        check("bus_err_o",  bus_err_o,  m_err);
        check("wb_stb_o",   wb_stb_o,   m_active);
        check("wb_cyc_o",   wb_cyc_o,   m_active);
        check("wb_adr_o",   wb_adr_o,   (m_active || m_gap) ? m_adr : '0);
        check("wb_dat_o",   wb_dat_o,   (m_active || m_gap) ? m_dat : '0);
        check("wb_we_o",    wb_we_o,    (m_active || m_gap) ? m_we  : 1'b0);
        check("wb_sel_o",   wb_sel_o,   (m_active || m_gap) ? m_sel : 4'h0);

        if (rst) begin
          m_active = 0; m_gap = 0; m_hold = 0; m_err = 0;
        end else begin
          m_err = 0;
          if (m_active) begin
            if (is_ack) begin
              m_active = 0; m_hold = (stall_i != 0); m_hold_data = m_we ? '0 : wb_dat_i;
            end else if (is_err) begin
              m_active = 0; m_err = 1; m_hold = (stall_i != 0); m_hold_data = '0;
            end else if (wb_rty_i) begin
              m_active = 0; m_gap = 1; m_tries++;
            end else if (flush_i) m_active = 0;
            else m_waited++;
          end else if (m_gap) begin
            m_gap = 0;
            if (!flush_i) begin m_active = 1; m_waited = 0; end
          end else if (m_hold) begin
            if (stall_i == 0) m_hold = 0;
          end else if (cpu_ce_i && !flush_i) begin
            m_adr = cpu_addr_i; m_dat = cpu_data_i; m_we = cpu_we_i; m_sel = cpu_sel_i;
            m_active = 1; m_tries = 0; m_waited = 0;
          end
        end
      end
    end
  end

  logic          s_stall, s_err, s_stb;
  logic [DW-1:0] s_data;
  logic          err_seen;

  task automatic step();
    @(negedge clk);
    s_stall = stallreq_o; s_data = cpu_data_o; s_err = bus_err_o; s_stb = wb_stb_o;
    if (bus_err_o) err_seen = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cpu_ce_i = 0; flush_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
  endtask

  task automatic request(input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [3:0] sel);
    cpu_ce_i = 1; cpu_we_i = we; cpu_addr_i = adr; cpu_data_i = dat; cpu_sel_i = sel;
    step();
    cpu_ce_i = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int cnt;
    err_seen = 0;
    // Reset with a pending CPU request: outputs must stay quiet.
    cpu_ce_i = 1;
    step();
    check("rst_stallreq", s_stall, 1'b0);
    step();
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_adr", wb_adr_o, 32'h0);
    check("rst_buserr", bus_err_o, 1'b0);
    rst = 0; cpu_ce_i = 0; chk_en = 1;
    step();

    // Read 0x100, two wait states, then ack.
    cnt = 0;
    request(1'b0, 32'h100, 32'h0, 4'hF);
    if (s_stall) cnt++;
    check("rd_adr", wb_adr_o, 32'h100);
    step(); if (s_stall) cnt++;
    step(); if (s_stall) cnt++;
    wb_ack_i = 1; wb_dat_i = 32'hDEADBEEF;
    step();
    check("rd_ack_data", s_data, 32'hDEADBEEF);
    check("rd_ack_stall", s_stall, 1'b0);
    check("rd_stall_cycles", cnt, 3);
    idle_in();
    step();
    check("rd_idle_stb", s_stb, 1'b0);
    check("rd_idle_stall", s_stall, 1'b0);

    // Write 0x200 acked under a pipeline stall -> parked, CPU request ignored.
    request(1'b1, 32'h200, 32'h12345678, 4'hF);
    check("wr_dat", wb_dat_o, 32'h12345678);
    check("wr_we", wb_we_o, 1'b1);
    check("wr_sel", wb_sel_o, 4'hF);
    stall_i = 6'b000100; wb_ack_i = 1;
    step();
    check("wr_ack_stall", s_stall, 1'b0);
    idle_in(); cpu_ce_i = 1;
    step();
    check("hold_ignores_ce", s_stall, 1'b0);
    check("hold_no_stb", wb_stb_o, 1'b0);
    cpu_ce_i = 0; stall_i = '0;
    step();

    // Read parked in hold: buffered data visible until the stall clears.
    request(1'b0, 32'h204, 32'h0, 4'h3);
    check("idle_after_hold", s_stall, 1'b1);
    stall_i = 6'd3; wb_ack_i = 1; wb_dat_i = 32'hA5A50F0F;
    step();
    idle_in();
    step();
    check("hold_data", s_data, 32'hA5A50F0F);
    stall_i = '0;
    step();
    check("hold_last", s_data, 32'hA5A50F0F);
    step();
    check("hold_released", s_data, 32'h0);

    // Three retries then ack.
    err_seen = 0; cnt = 0;
    request(1'b0, 32'h300, 32'h0, 4'hF);
    for (int a = 0; a < 4; a++) begin
      wb_rty_i = (a < 3); wb_ack_i = (a == 3); wb_dat_i = 32'hCAFEF00D;
      step();
      if (a < 3) begin
        idle_in();
        step();
        if (!s_stb) cnt++;
      end
    end
    check("rty_ack_data", s_data, 32'hCAFEF00D);
    idle_in();
    step();
    check("rty_gaps", cnt, 3);
    check("rty_no_err", err_seen, 1'b0);

    // Four retries: the last one becomes an error.
    request(1'b0, 32'h304, 32'h0, 4'hF);
    for (int a = 0; a < 4; a++) begin
      wb_rty_i = 1;
      step();
      if (a < 3) begin idle_in(); step(); end
    end
    check("rty_spent_stall", s_stall, 1'b0);
    idle_in();
    step();
    check("rty_spent_err", s_err, 1'b1);
    check("rty_spent_stb", s_stb, 1'b0);
    step();
    check("rty_err_pulse", s_err, 1'b0);

    // Silent slave: timeout after four busy cycles.
    cnt = 0;
    request(1'b0, 32'h400, 32'h0, 4'hF);
    for (int a = 0; a < 4; a++) begin
      step();
      if (s_stb) cnt++;
    end
    check("to_busy_cycles", cnt, 4);
    check("to_last_stall", s_stall, 1'b0);
    step();
    check("to_err", s_err, 1'b1);
    check("to_stb", s_stb, 1'b0);
    check("to_stall", s_stall, 1'b0);
    step();
    check("to_err_pulse", s_err, 1'b0);

    // Slave error with a pipeline stall: error pulse, parked with zero data.
    request(1'b0, 32'h480, 32'h0, 4'hF);
    wb_err_i = 1; wb_dat_i = 32'h11111111; stall_i = 6'b100000;
    step();
    check("err_data", s_data, 32'h0);
    idle_in();
    step();
    check("err_pulse", s_err, 1'b1);
    check("err_hold_data", s_data, 32'h0);
    stall_i = '0;
    step();

    // Flush mid-busy.
    err_seen = 0;
    request(1'b0, 32'h500, 32'h0, 4'hF);
    step();
    flush_i = 1;
    step();
    flush_i = 0;
    check("flush_stb", wb_stb_o, 1'b0);
    check("flush_adr", wb_adr_o, 32'h0);
    step();
    check("flush_no_err", err_seen, 1'b0);

    // Flush during a retry gap, and a flushed request in idle.
    request(1'b1, 32'h504, 32'h77, 4'h1);
    wb_rty_i = 1;
    step();
    wb_rty_i = 0; flush_i = 1;
    step();
    flush_i = 0;
    check("gap_flush_stb", wb_stb_o, 1'b0);
    check("gap_flush_dat", wb_dat_o, 32'h0);
    cpu_ce_i = 1; flush_i = 1;
    step();
    check("idle_flush_stall", s_stall, 1'b0);
    check("idle_flush_stb", wb_stb_o, 1'b0);
    idle_in();
    step();

    // Ack and err together: ack wins.
    err_seen = 0;
    request(1'b0, 32'h600, 32'h0, 4'hF);
    wb_ack_i = 1; wb_err_i = 1; wb_dat_i = 32'h55AA55AA;
    step();
    check("ackerr_data", s_data, 32'h55AA55AA);
    idle_in();
    step();
    check("ackerr_no_err", err_seen, 1'b0);

    // Reset mid-busy.
    request(1'b1, 32'h700, 32'h89ABCDEF, 4'hC);
    step();
    rst = 1;
    step();
    check("rst_busy_stall", s_stall, 1'b0);
    check("rst_busy_data", s_data, 32'h0);
    rst = 0;
    check("rst_busy_stb", wb_stb_o, 1'b0);
    check("rst_busy_cyc", wb_cyc_o, 1'b0);
    check("rst_busy_adr", wb_adr_o, 32'h0);
    check("rst_busy_dat", wb_dat_o, 32'h0);
    check("rst_busy_we", wb_we_o, 1'b0);
    check("rst_busy_sel", wb_sel_o, 4'h0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wishbone_master_if_p.md
WISHBONE_MASTER_IF_P -- requirements
Module: wishbone_master_if_p

Interface
REQ-001 SHALL have parameter DW, default 32, data width (multiple of 8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter STALL_W, default 6, pipeline stall vector width.
REQ-004 SHALL have parameter MAX_RETRY, default 3, max reissues after wb_rty_i.
REQ-005 SHALL have parameter TIMEOUT, default 255, BUSY cycles before abort; 0 disables.
REQ-006 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-007 SHALL have ports:
- clk  in  1  clock
- rst  in  1  sync reset
- stall_i  in  STALL_W  pipeline stall vector
- flush_i  in  1  pipeline flush
- cpu_ce_i  in  1  CPU request
- cpu_we_i  in  1  1 = write
- cpu_addr_i  in  AW  request address
- cpu_data_i  in  DW  write data
- cpu_sel_i  in  DW/8  byte selects
- cpu_data_o  out  DW  read data to CPU
- stallreq_o  out  1  stall request to pipeline
- bus_err_o  out  1  one-cycle error pulse
- wb_dat_i  in  DW  slave read data
- wb_ack_i / wb_err_i / wb_rty_i  in  1 each  slave termination
- wb_adr_o  out  AW
- wb_dat_o  out  DW
- wb_we_o  out  1
- wb_sel_o  out  DW/8
- wb_stb_o / wb_cyc_o  out  1 each

Function
REQ-008 SHALL implement states IDLE, BUSY, RETRY, HOLD; all wb_* outputs registered; wb_cyc_o always equals wb_stb_o.
REQ-009 IDLE, cpu_ce_i=1 and flush_i=0: next edge latch addr/cpu_data_i/we/sel onto wb_*, stb=cyc=1, retry count and timer = 0, go BUSY; stallreq_o=1 combinationally in that cycle.
REQ-010 BUSY termination priority SHALL be ack > err > rty > timeout > flush.
REQ-011 BUSY, ack: same cycle stallreq_o=0 and cpu_data_o=wb_dat_i (read) else 0; next edge all wb_* to 0, read data into rd_buf, go HOLD if stall_i!=0 else IDLE.
REQ-012 BUSY, err: same cycle stallreq_o=0, cpu_data_o=0; next edge wb_* to 0, rd_buf=0, bus_err_o=1 for exactly one cycle, go HOLD if stall_i!=0 else IDLE.
REQ-013 BUSY, rty with count<MAX_RETRY: next edge stb=cyc=0, count+1, go RETRY; with count==MAX_RETRY: treat as err.
REQ-014 BUSY timer SHALL increment each non-terminated cycle; timer==TIMEOUT-1 with no termination (TIMEOUT!=0) SHALL be treated as err.
REQ-015 BUSY, flush_i=1, no termination: next edge wb_* to 0, rd_buf=0, go IDLE, no bus_err_o.
REQ-016 RETRY lasts one cycle, stallreq_o=1; flush_i=1 -> IDLE with wb_* cleared; else reassert stb=cyc with latched request, timer=0, go BUSY.
REQ-017 HOLD: stallreq_o=0, cpu_data_o=rd_buf; go IDLE when stall_i==0; new cpu_ce_i ignored.
REQ-018 stallreq_o=1 throughout BUSY without termination; cpu_data_o=0 in every state/cycle not listed above.

Reset
REQ-019 rst=1 at any edge, including mid-transaction, SHALL force IDLE, all wb_* outputs 0, rd_buf/count/timer 0, bus_err_o=0; while rst=1 stallreq_o=0, cpu_data_o=0.

Verification
REQ-020 Read 0x100, ack after 2 wait cycles with wb_dat_i=0xDEADBEEF, stall_i=0 -> stallreq_o high 3 cycles, cpu_data_o=0xDEADBEEF on ack cycle, IDLE next.
REQ-021 Write 0x200 data 0x12345678 sel 0xF -> wb_dat_o=0x12345678, wb_we_o=1, wb_sel_o=0xF; ack with stall_i=6'b000100 -> HOLD, IDLE when stall_i=0.
REQ-022 Read with rty on first 3 attempts, ack on 4th (MAX_RETRY=3) -> stb low one cycle between attempts, data returned, bus_err_o never set; rty on 4th -> bus_err_o pulse.
REQ-023 TIMEOUT=4, no slave response -> stb drops after 4 BUSY cycles, bus_err_o one-cycle pulse, stallreq_o released.
REQ-024 flush_i mid-BUSY -> wb_* cleared next edge, no error; ack+err same cycle -> ack path only; rst mid-BUSY -> all outputs zero next edge.
